// File: rtl/ebus_diag_responder_pkg.sv
// ebus_diag_responder_pkg
// Shared backplane definitions for the EBUS diagnostic responder slice:
//   DIAG_FUNC_W    - width of a front-end diagnostic function code
//   EBUS_W         - width of the EBUS data path
//   tEBUSdriver    - one device's contribution to the top-level EBUS mux
//   tDiagRespState - diagnostic responder FSM states
package ebus_diag_responder_pkg;

  localparam int DIAG_FUNC_W = 7;
  localparam int EBUS_W      = 36;

  // The top-level mux ORs every device's .data together, so .data must be
  // zero whenever .driving is low.
  typedef struct packed {
    logic              driving;
    logic [EBUS_W-1:0] data;
  } tEBUSdriver;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_WRITE   = 3'd4,
    ST_WAITLOW = 3'd5
  } tDiagRespState;

endpackage

// File: rtl/ebus_diag_responder_strobe_edge.sv
// diag_strobe_edge
// Registers the front-end diagnostic strobe and produces single-cycle
// rise and fall pulses relative to the registered copy.
// Ports:
//   clk, reset_l - board clock, asynchronous active-low reset
//   strobe       - diagnostic strobe, synchronous to clk
//   rise         - strobe high now, low last cycle
//   fall         - strobe low now, high last cycle
module diag_strobe_edge (
  input  logic clk,
  input  logic reset_l,
  input  logic strobe,
  output logic rise,
  output logic fall
);

  logic strobe_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe;
    end
  end

  assign rise = strobe & ~strobe_q;
  assign fall = ~strobe & strobe_q;

endmodule

// File: rtl/ebus_diag_responder.sv
// ebus_diag_responder
// Device end of the front-end diagnostic EBUS protocol for one board slice.
// A read function in range snapshots one local register and drives it on
// EBUSdriver after a settling delay; a write function captures EBUS data
// and pulses wr_load to the owning board logic.
//
// Strobe handshake: a transaction starts only on the rising edge of
// diag_strobe; diag_func is sampled at that edge alone. A read drives the
// bus until the strobe is seen low, then spends one RELEASE cycle off the
// bus before accepting the next rise. A write pulses wr_load once and then
// waits for the strobe to go low. Function codes outside the owned range
// are ignored entirely.
//
// Parameters:
//   BASE_FUNC - first owned diagnostic function code
//   NREG      - number of owned function codes (1..8)
//   SETUP_CYC - cycles from strobe rise to driving (0..7)
// Ports:
//   clk, reset_l   - board clock, asynchronous active-low reset
//   diag_strobe    - front-end diagnostic strobe
//   diag_func      - function code; bit 0 set = write, bits [6:1] = code
//   ebus_in        - resolved EBUS data
//   rd_data        - NREG packed local register values, entry 0 in LSBs
//   wr_data        - captured EBUS data of the last write
//   wr_sel         - register index of the last write
//   wr_load        - one-cycle write pulse
//   EBUSdriver     - bus contribution (.driving, .data)
//   busy           - FSM not in IDLE
//   contention_err - sticky bus contention flag
//   fsm_state      - current FSM state, for debug
// Build option: define EBUS_CONTENTION_CHECK_EN to compare the resolved
// bus against the driven snapshot while driving; otherwise contention_err
// is tied low.
module ebus_diag_responder
  import ebus_diag_responder_pkg::*;
#(
  parameter logic [DIAG_FUNC_W-1:0] BASE_FUNC = 7'o100,
  parameter int                     NREG      = 4,
  parameter int                     SETUP_CYC = 2
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic                     diag_strobe,
  input  logic [DIAG_FUNC_W-1:0]   diag_func,
  input  logic [EBUS_W-1:0]        ebus_in,
  input  logic [NREG*EBUS_W-1:0]   rd_data,
  output logic [EBUS_W-1:0]        wr_data,
  output logic [2:0]               wr_sel,
  output logic                     wr_load,
  output tEBUSdriver               EBUSdriver,
  output logic                     busy,
  output logic                     contention_err,
  output tDiagRespState            fsm_state
);

  localparam logic [5:0] BASE_CODE  = BASE_FUNC[6:1];
  localparam logic [2:0] SETUP_LAST = 3'(SETUP_CYC - 1);

  tDiagRespState     state;
  logic              rise;
  logic              fall;
  logic [5:0]        code;
  logic [5:0]        offs;
  logic              hit;
  logic [2:0]        idx;
  logic              is_write;
  logic [EBUS_W-1:0] rd_arr [8];
  logic [EBUS_W-1:0] snap;
  logic [2:0]        setup_cnt;
  tEBUSdriver        drv;

  diag_strobe_edge u_strobe_edge (
    .clk     (clk),
    .reset_l (reset_l),
    .strobe  (diag_strobe),
    .rise    (rise),
    .fall    (fall)
  );

  // Function decode: bits [6:1] select the register, bit 0 the direction.
  assign code     = diag_func[6:1];
  assign offs     = code - BASE_CODE;
  assign hit      = (code >= BASE_CODE) && (offs < 6'(NREG));
  assign idx      = offs[2:0];
  assign is_write = diag_func[0];

  // Unpack rd_data into a full 8-entry table so a 3-bit index is always
  // in bounds; unused entries read as zero and are never selected on a hit.
  for (genvar i = 0; i < 8; i++) begin : g_rd_arr
    if (i < NREG) begin : g_used
      assign rd_arr[i] = rd_data[i*EBUS_W +: EBUS_W];
    end else begin : g_unused
      assign rd_arr[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= ST_IDLE;
      snap      <= '0;
      setup_cnt <= '0;
      drv       <= '0;
      wr_data   <= '0;
      wr_sel    <= '0;
      wr_load   <= 1'b0;
    end else begin
      wr_load <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise && hit) begin
            if (is_write) begin
              // Capture at the transition so wr_load, wr_data and wr_sel
              // are all valid together in the WRITE cycle.
              wr_data <= ebus_in;
              wr_sel  <= idx;
              wr_load <= 1'b1;
              state   <= ST_WRITE;
            end else begin
              snap      <= rd_arr[idx];
              setup_cnt <= '0;
              if (SETUP_CYC == 0) begin
                drv.driving <= 1'b1;
                drv.data    <= rd_arr[idx];
                state       <= ST_DRIVE;
              end else begin
                state <= ST_SETUP;
              end
            end
          end
        end
        ST_SETUP: begin
          // A fall before the settling time expires aborts the read.
          if (fall) begin
            state <= ST_RELEASE;
          end else if (setup_cnt == SETUP_LAST) begin
            drv.driving <= 1'b1;
            drv.data    <= snap;
            state       <= ST_DRIVE;
          end else begin
            setup_cnt <= setup_cnt + 3'd1;
          end
        end
        ST_DRIVE: begin
          if (fall) begin
            drv   <= '0;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
        ST_WRITE: begin
          state <= ST_WAITLOW;
        end
        ST_WAITLOW: begin
          if (!diag_strobe) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          drv   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign EBUSdriver = drv;
  assign busy       = (state != ST_IDLE);
  assign fsm_state  = state;

`ifdef EBUS_CONTENTION_CHECK_EN
  // The first DRIVE cycle is excluded: the bus needs a cycle to resolve to
  // our value before a mismatch means another driver is fighting us.
  logic drive_seen;
  logic err;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      drive_seen <= 1'b0;
      err        <= 1'b0;
    end else begin
      drive_seen <= (state == ST_DRIVE);
      if ((state == ST_DRIVE) && drive_seen && (ebus_in != snap)) begin
        err <= 1'b1;
      end
    end
  end

  assign contention_err = err;
`else
  assign contention_err = 1'b0;
`endif

endmodule

// File: tb/tb_ebus_diag_responder.sv
// tb_ebus_diag_responder
// Self-checking bench for ebus_diag_responder with default parameters.
// Build option: EBUS_CONTENTION_CHECK_EN selects the expected behaviour
// of contention_err.
module tb_ebus_diag_responder;
  import ebus_diag_responder_pkg::*;

  localparam logic [6:0] BASE_FUNC = 7'o100;
  localparam int         NREG      = 4;
  localparam int         S         = 2;
`ifdef EBUS_CONTENTION_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  logic                 diag_strobe = 1'b0;
  logic [6:0]           diag_func = '0;
  logic [35:0]          ebus_in = '0;
  logic [NREG*36-1:0]   rd_data;
  logic [35:0]          wr_data;
  logic [2:0]           wr_sel;
  logic                 wr_load;
  tEBUSdriver           EBUSdriver;
  logic                 busy;
  logic                 contention_err;
  tDiagRespState        fsm_state;

  logic [35:0] rd_val [NREG];

  ebus_diag_responder #(
    .BASE_FUNC (BASE_FUNC),
    .NREG      (NREG),
    .SETUP_CYC (S)
  ) dut (
    .clk            (clk),
    .reset_l        (reset_l),
    .diag_strobe    (diag_strobe),
    .diag_func      (diag_func),
    .ebus_in        (ebus_in),
    .rd_data        (rd_data),
    .wr_data        (wr_data),
    .wr_sel         (wr_sel),
    .wr_load        (wr_load),
    .EBUSdriver     (EBUSdriver),
    .busy           (busy),
    .contention_err (contention_err),
    .fsm_state      (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [35:0] m_wdata = '0;
  logic [2:0]  m_wsel = '0;
  logic        m_err = 1'b0;

  // per-transaction measurements
  int          drive_n;
  int          drive_first;
  logic [35:0] drive_val;
  int          load_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] rand36();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[35:0];
  endfunction

  task automatic pack_rd();
    rd_data = {rd_val[3], rd_val[2], rd_val[1], rd_val[0]};
  endtask

  // ---------------- driver + reference model ----------------
  // One strobe transaction: strobe high for cycles 0..len-1, low from len.
  // Expected outputs per cycle come from the protocol timing rules:
  //   read hit : driving in cycles [1+S, len], busy in [1, len+1]
  //   write hit: wr_load in cycle 1, busy in [1, max(len,2)]
  //   miss     : nothing
  task automatic run_txn(input logic [6:0] f, input int len, input logic [35:0] ebv,
                         input bit scramble, input bit contend);
    int          off;
    bit          hit;
    bit          wr;
    logic [35:0] s;
    bit          e_drv;
    bit          e_busy;
    bit          e_load;
    off = int'(f) / 2 - int'(BASE_FUNC) / 2;
    hit = (off >= 0) && (off < NREG);
    wr  = (int'(f) % 2) == 1;
    s   = hit ? rd_val[off] : '0;
    drive_n = 0; drive_first = -1; drive_val = '0; load_n = 0;
    for (int c = 0; c <= len + 4; c++) begin
      e_drv  = hit && !wr && (c >= 1 + S) && (c <= len);
      e_load = hit && wr && (c == 1);
      e_busy = hit && (c >= 1) && (wr ? (c <= ((len > 2) ? len : 2)) : (c <= len + 1));
      if (e_load) begin
        m_wdata = ebv;
        m_wsel  = 3'(off);
      end
      if (contend && CHK_EN && !wr && hit && (len >= 2 + S) && (c >= 3 + S)) m_err = 1'b1;
      diag_strobe = (c < len);
      if (c == 0) begin
        diag_func = f;
        ebus_in   = ebv;
      end else begin
        if (scramble) begin
          diag_func = 7'($urandom());
          for (int k = 0; k < NREG; k++) rd_val[k] = rand36();
          pack_rd();
        end
        // the resolved bus carries our value while we drive it
        if (e_drv) ebus_in = contend ? (s ^ 36'h20) : s;
        else if (scramble) ebus_in = rand36();
      end
      @(negedge clk);
      chk("driving", 64'(EBUSdriver.driving), 64'(e_drv));
      chk("data", 64'(EBUSdriver.data), 64'(e_drv ? s : 36'h0));
      chk("wr_load", 64'(wr_load), 64'(e_load));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("wr_data", 64'(wr_data), 64'(m_wdata));
      chk("wr_sel", 64'(wr_sel), 64'(m_wsel));
      chk("contention_err", 64'(contention_err), 64'(m_err));
      if (EBUSdriver.driving) begin
        if (drive_n == 0) drive_first = c;
        drive_n++;
        drive_val = EBUSdriver.data;
      end
      if (wr_load) load_n++;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [6:0]  func;
    int          len;
    logic [35:0] ebv;
    int          exp_drive_n;
    int          exp_first;
    logic [35:0] exp_dval;
    int          exp_load_n;
    logic [2:0]  exp_sel;
    logic [35:0] exp_wdata;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_val[0] = 36'o111111_000000;
    rd_val[1] = 36'o222222_333333;
    rd_val[2] = 36'o123456_701234;
    rd_val[3] = 36'o765432_101234;
    pack_rd();

    tbl[0]  = '{7'o104, 8, 36'o0,             6, 3, 36'o123456_701234, 0, 3'd0, 36'o0};
    tbl[1]  = '{7'o103, 4, 36'o777000_000777, 0, 0, 36'o0,             1, 3'd1, 36'o777000_000777};
    tbl[2]  = '{7'o110, 4, 36'o555,           0, 0, 36'o0,             0, 3'd0, 36'o0};
    tbl[3]  = '{7'o104, 1, 36'o0,             0, 0, 36'o0,             0, 3'd0, 36'o0};
    tbl[4]  = '{7'o100, 3, 36'o0,             1, 3, 36'o111111_000000, 0, 3'd0, 36'o0};
    tbl[5]  = '{7'o106, 5, 36'o0,             3, 3, 36'o765432_101234, 0, 3'd0, 36'o0};
    tbl[6]  = '{7'o107, 2, 36'o123,           0, 0, 36'o0,             1, 3'd3, 36'o123};
    tbl[7]  = '{7'o076, 6, 36'o0,             0, 0, 36'o0,             0, 3'd0, 36'o0};
    tbl[8]  = '{7'o101, 1, 36'o456,           0, 0, 36'o0,             1, 3'd0, 36'o456};
    tbl[9]  = '{7'o102, 4, 36'o0,             2, 3, 36'o222222_333333, 0, 3'd0, 36'o0};
    tbl[10] = '{7'o105, 3, 36'o7,             0, 0, 36'o0,             1, 3'd2, 36'o7};
    tbl[11] = '{7'o117, 5, 36'o0,             0, 0, 36'o0,             0, 3'd0, 36'o0};

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_driving", 64'(EBUSdriver.driving), 64'(0));
    chk("rst_data", 64'(EBUSdriver.data), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_wr_sel", 64'(wr_sel), 64'(0));
    chk("rst_wr_load", 64'(wr_load), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(contention_err), 64'(0));
    chk("rst_state", 64'(fsm_state), 64'(ST_IDLE));
    @(posedge clk);
    #1 reset_l = 1'b1;
    @(posedge clk);
    #1;

    // directed table
    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i].func, tbl[i].len, tbl[i].ebv, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_drive_n", i), 64'(drive_n), 64'(tbl[i].exp_drive_n));
      chk($sformatf("tbl%0d_load_n", i), 64'(load_n), 64'(tbl[i].exp_load_n));
      if (tbl[i].exp_drive_n > 0) begin
        chk($sformatf("tbl%0d_first", i), 64'(drive_first), 64'(tbl[i].exp_first));
        chk($sformatf("tbl%0d_dval", i), 64'(drive_val), 64'(tbl[i].exp_dval));
      end
      if (tbl[i].exp_load_n > 0) begin
        chk($sformatf("tbl%0d_wsel", i), 64'(wr_sel), 64'(tbl[i].exp_sel));
        chk($sformatf("tbl%0d_wdata", i), 64'(wr_data), 64'(tbl[i].exp_wdata));
      end
    end

    // randomized transactions with snapshot/function scrambling mid-transaction
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NREG; k++) rd_val[k] = rand36();
      pack_rd();
      run_txn(7'($urandom_range('o120, 'o070)), $urandom_range(10, 1), rand36(), 1'b1, 1'b0);
    end

    // reset asserted while driving
    rd_val[2] = 36'o123456_701234;
    pack_rd();
    diag_func = 7'o104;
    ebus_in = rd_val[2];
    diag_strobe = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_driving", 64'(EBUSdriver.driving), 64'(1));
    #2;
    reset_l = 1'b0;
    diag_strobe = 1'b0;
    m_wdata = '0;
    m_wsel = '0;
    m_err = 1'b0;
    #1;
    chk("async_rst_driving", 64'(EBUSdriver.driving), 64'(0));
    chk("async_rst_data", 64'(EBUSdriver.data), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_wr_data", 64'(wr_data), 64'(0));
    @(posedge clk);
    #1 reset_l = 1'b1;
    @(posedge clk);
    #1;
    run_txn(7'o104, 5, 36'o0, 1'b0, 1'b0);
    chk("post_rst_drive_n", 64'(drive_n), 64'(3));

    // contention: resolved bus bit 5 opposite to the snapshot while driving
    run_txn(7'o104, 8, 36'o0, 1'b0, 1'b1);
    run_txn(7'o102, 5, 36'o0, 1'b0, 1'b0);
    chk("err_sticky", 64'(contention_err), 64'(CHK_EN));
    reset_l = 1'b0;
    m_err = 1'b0;
    m_wdata = '0;
    m_wsel = '0;
    #1;
    chk("err_cleared", 64'(contention_err), 64'(0));
    @(posedge clk);
    #1 reset_l = 1'b1;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ebus_diag_responder.md
# ebus_diag_responder

Generic EBUS diagnostic responder for a KL10PV board slice. It decodes front-end diagnostic functions from the DIAG strobe and function lines. On a read function in its range it snapshots one local register and presents it on its `tEBUSdriver` port, which the top-level EBUS mux selects. On a write function it captures EBUS data and pulses a load to the owning board logic. It is the device end of the front-end diagnostic EBUS protocol.

## Interface
Parameters:
- `BASE_FUNC`, default 7'o100: first diagnostic function code owned by this block.
- `NREG`, default 4: number of function codes owned, covering reads and writes (1..8).
- `SETUP_CYC`, default 2: cycles from strobe rise to `driving`, giving EBUS settling time (0..7).

Ports:
- `clk` in 1: board clock.
- `reset_l` in 1: asynchronous, active-low reset.
- `diag_strobe` in 1: front-end diagnostic strobe, synchronous to `clk`.
- `diag_func` in 7: diagnostic function code, bits [0:6]. Bit 0 set means write, clear means read.
- `ebus_in` in 36: resolved EBUS data, bits [0:35].
- `rd_data` in NREG×36: local register values.
- `wr_data` out 36: captured EBUS data.
- `wr_sel` out 3: register index of the write.
- `wr_load` out 1: one-cycle write pulse.
- `EBUSdriver` out tEBUSdriver: fields `.driving` and `.data`.
- `busy` out 1: FSM is not in IDLE.
- `contention_err` out 1: sticky error flag (see Configuration).

## Operation
- Decode: `hit` = `diag_func[1:6]` falls in `BASE_FUNC[1:6]` .. `BASE_FUNC[1:6]+NREG-1`. Index `idx` = `diag_func[1:6]` − `BASE_FUNC[1:6]`, truncated to 3 bits.
- Only the rising edge of `diag_strobe` starts a transaction. The rise is detected against a registered copy of the strobe.
- FSM states:
  - IDLE: on strobe rise with `hit`:
    - read function → latch `rd_data[idx]` into `snap`, go to SETUP.
    - write function → go to WRITE.
  - IDLE: on strobe rise without `hit` → stay in IDLE and never drive.
  - SETUP: count `SETUP_CYC` cycles → DRIVE. With `SETUP_CYC`=0, go directly to DRIVE on the next cycle.
  - DRIVE: `.driving`=1 and `.data`=`snap`. When strobe falls → RELEASE.
  - RELEASE: `.driving`=0 and `.data`=0 for one cycle → IDLE.
  - WRITE: capture `ebus_in` into `wr_data` and `idx` into `wr_sel`. Pulse `wr_load` for exactly one cycle, then go to WAITLOW.
  - WAITLOW: hold until strobe is low → IDLE.
- Strobe falls during SETUP → RELEASE, with no drive cycle. The read is aborted.
- `.data` is 0 whenever `.driving`=0. This keeps the mux OR-safe.
- `snap` is frozen for the whole transaction. Changes on `rd_data` after capture are ignored.
- The function code is sampled only at the strobe rise. Changes to `diag_func` while the strobe is high are ignored.
- Reset asserted mid-transaction: the block returns to IDLE immediately and all outputs go to 0.

## Timing
- Reset values: `.driving`=0, `.data`=0, `wr_data`=0, `wr_sel`=0, `wr_load`=0, `busy`=0, `contention_err`=0.
- Read latency: strobe rises at cycle 0 → `snap` is loaded at the cycle-1 edge → `.driving`=1 from cycle 1+`SETUP_CYC`.
- Release: the strobe-low sample at cycle k makes `.driving`=0 from cycle k+1. The next transaction can be accepted from cycle k+2.
- Write: strobe rises at cycle 0 → `wr_load`=1 during cycle 1 only, with `wr_data` and `wr_sel` valid in that same cycle. `wr_data` and `wr_sel` hold until the next write.
- `busy` is high in every state except IDLE.

## Configuration
- `EBUS_CONTENTION_CHECK_EN` defined:
  - In DRIVE, from the second DRIVE cycle onward, any `ebus_in` ≠ `snap` sets `contention_err`.
  - The flag is cleared only by reset.
- `EBUS_CONTENTION_CHECK_EN` undefined: `contention_err` is tied to 0 and no compare logic exists.

## Structure
- `tEBUSdriver` and the FSM state enum live in the shared backplane package/header. The state enum is named `tDiagRespState`.
- `DIAG_FUNC_W`=7 and `EBUS_W`=36 are defined in that package.
- One sub-module, `diag_strobe_edge`: registers the strobe and outputs the rise and fall pulses.

## Test plan
- Read with defaults: `rd_data[2]`=36'o123456_701234, strobe rises at cycle 0 with func 7'o104 → `.driving`=1 from cycle 3 with that data. Strobe falls at cycle 8 → `.driving`=0 at cycle 9.
- Write: func 7'o103, `ebus_in`=36'o777000_000777 → at cycle 1, `wr_load`=1 for one cycle, `wr_sel`=1, `wr_data`=36'o777000_000777.
- Miss: func 7'o110 (out of range) → `.driving` and `wr_load` stay 0 and `busy` stays 0.
- Abort: strobe high for a single cycle on a read with `SETUP_CYC`=2 → `.driving` never asserts and the FSM returns to IDLE.
- Reset while in DRIVE → `.driving`=0 asynchronously, and the next read behaves normally.
- With `EBUS_CONTENTION_CHECK_EN` defined: force `ebus_in` bit 5 opposite to `snap` during DRIVE → `contention_err`=1 and it stays set until reset.
